axis_rr_arbiter: RTL

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axil_str_pkg.sv | 20 ++
 rtl/axis_skid_buffer.sv | 62 ++++++
 rtl/axis_rr_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axil_str_pkg.sv
// -----------------------------------------------------------------------------
// axil_str_pkg
// Shared definitions for the stream arbitration path:
//   arb_state_t - arbiter FSM state encoding (IDLE / GRANT)
//   tid_width() - width of the source-index (TID) field for a given source count
// -----------------------------------------------------------------------------
package axil_str_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // A single source still needs a 1-bit TID so the port never collapses to
    // zero width.
    function automatic int tid_width(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// -----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry stream buffer: an output register plus one skid register.
// Handshake: a beat moves on either side only in a cycle where valid and ready
// are both high at the rising edge; a valid beat is held stable until taken.
// Ports:
//   aclk, aresetn  - clock, asynchronous active-low reset
//   s_data/s_valid - upstream beat in
//   s_ready        - high while the skid register is empty
//   m_data/m_valid - registered beat out
//   m_ready        - downstream ready
// -----------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;

    // Upstream may only push while there is somewhere to park a stalled beat.
    assign s_ready = ~skid_valid;
    assign m_data  = out_data;
    assign m_valid = out_valid;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (!out_valid || m_ready) begin
            // Output register is free this cycle: refill from the skid entry
            // first (it is older), otherwise straight from the input.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= s_valid;
                if (s_valid) begin
                    out_data <= s_data;
                end
            end
        end else if (s_valid && !skid_valid) begin
            // Output stalled: absorb the in-flight beat into the skid entry.
            skid_data  <= s_data;
            skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// -----------------------------------------------------------------------------
// axis_rr_arbiter
// Round-robin arbiter that merges NUM_SRC stream producers onto one stream.
// A grant lasts up to BURST_LEN beats, or until the granted source drops valid;
// each new arbitration spends one IDLE cycle. Beats pass through a two-entry
// skid buffer and carry their source index on m_axis_tid.
// Handshake: a beat transfers on a port only when tvalid and tready are both
// high at the rising edge of aclk; tvalid/tdata/tid hold while tready is low.
// Ports:
//   aclk, aresetn   - clock, asynchronous active-low reset
//   s_axis_tdata    - packed producer data, source i in slice i
//   s_axis_tvalid   - per-source valid
//   s_axis_tready   - per-source ready (only the granted source may be high)
//   m_axis_tdata    - arbitrated data
//   m_axis_tvalid   - arbitrated valid
//   m_axis_tready   - downstream ready
//   m_axis_tid      - source index of the current m_axis beat
//   busy            - FSM is in GRANT (doubles as the FSM state view)
// -----------------------------------------------------------------------------
module axis_rr_arbiter
    import axil_str_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_SRC        = 2,
    parameter int BURST_LEN      = 4
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]                s_axis_tvalid,
    output logic [NUM_SRC-1:0]                s_axis_tready,
    output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [tid_width(NUM_SRC)-1:0]     m_axis_tid,
    output logic                              busy
);

    localparam int TID_W = tid_width(NUM_SRC);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int BUF_W = AXI_DATA_WIDTH + TID_W;

    arb_state_t                state;
    logic [TID_W-1:0]          grant;
    logic [TID_W-1:0]          last_grant;
    logic [CNT_W-1:0]          beat_cnt;

    logic                      rr_found;
    logic [TID_W-1:0]          rr_pick;
    logic                      sel_valid;
    logic [AXI_DATA_WIDTH-1:0] sel_data;
    logic                      buf_s_valid;
    logic                      buf_s_ready;
    logic                      beat_hs;

    // Round-robin search: first valid source starting just above last_grant.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!rr_found && (i == (int'(last_grant) + k) % NUM_SRC)
                    && s_axis_tvalid[i]) begin
                    rr_found = 1'b1;
                    rr_pick  = TID_W'(i);
                end
            end
        end
    end

    // Granted-source mux.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant == TID_W'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_data  = s_axis_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Only the granted source sees ready, and only while the skid entry is free.
    always_comb begin
        s_axis_tready = '0;
        if (state == ST_GRANT) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                s_axis_tready[i] = (grant == TID_W'(i)) && buf_s_ready;
            end
        end
    end

    assign buf_s_valid = (state == ST_GRANT) && sel_valid;
    assign beat_hs     = buf_s_valid && buf_s_ready;
    assign busy        = (state == ST_GRANT);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= TID_W'(NUM_SRC - 1);  // source 0 wins first
            beat_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rr_found) begin
                        grant    <= rr_pick;
                        beat_cnt <= '0;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!sel_valid) begin
                        // Source went quiet: release early.
                        state      <= ST_IDLE;
                        last_grant <= grant;
                    end else if (beat_hs) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == CNT_W'(BURST_LEN - 1)) begin
                            state      <= ST_IDLE;
                            last_grant <= grant;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .DATA_W (BUF_W)
    ) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_data  ({grant, sel_data}),
        .s_valid (buf_s_valid),
        .s_ready (buf_s_ready),
        .m_data  ({m_axis_tid, m_axis_tdata}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule
